// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed N-digit hex display driver; define LEADING_ZERO_BLANK_EN to darken leading zero digits
module seg7_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blank,
  input  logic                    test,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] dataIn,
  output logic [6:0]              display,
  output logic [NUM_DIGITS-1:0]   anode
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [CW-1:0]           div_cnt_q, div_cnt_d;
  logic [IW-1:0]           dig_idx_q, dig_idx_d;
  logic [6:0]              display_q, display_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d, sel;
  logic [3:0]              nib;
  logic                    dark;
  logic                    tc;
  // capture, refresh divider and digit index; the index only moves on the divider's terminal count
  always_comb begin
    tc        = div_cnt_q == CW'(REFRESH_DIV - 1);
    data_d    = load ? dataIn : data_q;
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    dig_idx_d = !tc ? dig_idx_q : dig_idx_q == IW'(NUM_DIGITS - 1) ? '0 : dig_idx_q + 1'b1;
  end
  // next segment/enable pattern from the current index and captured data: blank > test > normal
  always_comb begin
    nib       = data_q[{dig_idx_q, 2'b00} +: 4];
    sel       = ~(NUM_DIGITS'(1) << dig_idx_q);
    dark      = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    dark      = dig_idx_q != '0 && (data_q >> {dig_idx_q, 2'b00}) == '0;
`endif
    display_d = blank ? 7'h7F : test ? 7'h00 : dark ? 7'h7F : HEX[nib];
    anode_d   = blank || (dark && !test) ? '1 : sel;
  end
  // state and registered outputs; reset forces every digit dark at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      div_cnt_q <= '0;
      dig_idx_q <= '0;
      display_q <= 7'h7F;
      anode_q   <= '1;
    end else begin
      data_q    <= data_d;
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      display_q <= display_d;
      anode_q   <= anode_d;
    end
  end
  assign display = display_q;
  assign anode   = anode_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of seg7_scan (4 digits / div 4, and 3 digits / div 1)
module tb_seg7_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b0;
  logic        test = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [6:0]  display, display2;
  logic [3:0]  anode;
  logic [2:0]  anode2;
  int          total = 0;
  int          passed = 0;
  logic [2:0]  a2 [3] = '{3'h6, 3'h5, 3'h3};
  logic [6:0]  d2 [3] = '{7'h79, 7'h24, 7'h30};
  logic [6:0]  exp_d;
  logic [3:0]  exp_a;

  always #5 clk = ~clk;

  seg7_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .blank(blank), .test(test), .load(load),
    .dataIn(data_in), .display(display), .anode(anode)
  );

  seg7_scan #(.NUM_DIGITS(3), .REFRESH_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .blank(1'b0), .test(1'b0), .load(load),
    .dataIn(12'h321), .display(display2), .anode(anode2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_disp", 16'(display), 16'h7F);
    chk("rst_anode", 16'(anode), 16'hF);
    chk("rst_anode2", 16'(anode2), 16'h7);
    reset = 1'b0;
    load = 1'b1;
    data_in = 16'h12AF;
    for (int k = 1; k <= 17; k++) begin
      step(1);
      if (k == 1) load = 1'b0;
      chk("div1_anode", 16'(anode2), 16'(a2[(k - 1) % 3]));
      if (k >= 2) chk("div1_disp", 16'(display2), 16'(d2[(k - 1) % 3]));
      exp_a = 4'h0;
      case (k)
        1:  begin exp_d = 7'h40; exp_a = 4'hE; end
        2:  begin exp_d = 7'h0E; exp_a = 4'hE; end
        5:  begin exp_d = 7'h08; exp_a = 4'hD; end
        9:  begin exp_d = 7'h24; exp_a = 4'hB; end
        13: begin exp_d = 7'h79; exp_a = 4'h7; end
        17: begin exp_d = 7'h0E; exp_a = 4'hE; end
        default: exp_d = 7'h00;
      endcase
      if (exp_a != 4'h0) begin
        chk("scan_disp", 16'(display), 16'(exp_d));
        chk("scan_anode", 16'(anode), 16'(exp_a));
      end
    end
    blank = 1'b1;
    test = 1'b1;
    step(1);
    chk("blank_disp", 16'(display), 16'h7F);
    chk("blank_anode", 16'(anode), 16'hF);
    blank = 1'b0;
    step(1);
    chk("test_disp", 16'(display), 16'h00);
    chk("test_anode", 16'(anode), 16'hE);
    step(2);
    chk("test_disp_adv", 16'(display), 16'h00);
    chk("test_anode_adv", 16'(anode), 16'hD);
    test = 1'b0;
    step(10);
    load = 1'b1;
    data_in = 16'h0005;
    step(1);
    load = 1'b0;
    step(1);
    chk("coll_disp0", 16'(display), 16'h12);
    chk("coll_anode0", 16'(anode), 16'hE);
    step(4);
`ifdef LEADING_ZERO_BLANK_EN
    chk("coll_disp1", 16'(display), 16'h7F);
    chk("coll_anode1", 16'(anode), 16'hF);
`else
    chk("coll_disp1", 16'(display), 16'h40);
    chk("coll_anode1", 16'(anode), 16'hD);
`endif
    step(4);
`ifdef LEADING_ZERO_BLANK_EN
    chk("coll_disp2", 16'(display), 16'h7F);
    chk("coll_anode2", 16'(anode), 16'hF);
`else
    chk("coll_disp2", 16'(display), 16'h40);
    chk("coll_anode2", 16'(anode), 16'hB);
`endif
    #2 reset = 1'b1;
    #1;
    chk("async_disp", 16'(display), 16'h7F);
    chk("async_anode", 16'(anode), 16'hF);
    chk("async_anode2", 16'(anode2), 16'h7);
    @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("restart_disp", 16'(display), 16'h40);
    chk("restart_anode", 16'(anode), 16'hE);
    step(3);
    chk("restart_hold", 16'(anode), 16'hE);
    step(1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("restart_next", 16'(anode), 16'hF);
`else
    chk("restart_next", 16'(anode), 16'hD);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
